// File: rtl/onehot_seq_dec.sv
// Sequenced index-to-one-hot decoder: queues indices from a valid/ready
// handshake in a small FIFO and drives each as a one-hot vector for HOLD cycles.
module onehot_seq_dec #(
    parameter int unsigned N     = 8,
    parameter int unsigned HOLD  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [$clog2(N)-1:0] idx,
    input  logic                 idx_valid,
    output logic                 idx_ready,
    output logic [N-1:0]         out,
    output logic                 out_valid,
    output logic                 busy
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [IW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [HW-1:0]   r_cnt;
    logic [HW-1:0]   w_cnt_nxt;
    logic [N-1:0]    r_out;
    logic [N-1:0]    w_out_nxt;
    logic            r_out_valid;
    logic            w_out_valid_nxt;

    logic            w_push;
    logic            w_pop;
    logic            w_nonempty;
    logic [IW-1:0]   w_head;
    logic [N-1:0]    w_head_dec;

    // Ready depends only on registered occupancy; a same-cycle pop does not open a full FIFO.
    assign idx_ready  = !rst && (r_count != FULL);
    assign w_push     = idx_valid && idx_ready;
    assign w_nonempty = (r_count != '0);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_dec = N'(1) << w_head;

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = r_out_valid || w_nonempty;

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next output, hold counter and pop decision.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_out_nxt       = r_out;
        w_out_valid_nxt = r_out_valid;
        w_pop           = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_out_nxt       = '0;
                w_out_valid_nxt = 1'b0;
                if (w_nonempty) begin
                    w_pop           = 1'b1;
                    w_out_nxt       = w_head_dec;
                    w_out_valid_nxt = 1'b1;
                    w_cnt_nxt       = HOLD_M1;
                    w_state_nxt     = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - HW'(1);
                end else if (w_nonempty) begin
                    // Reload straight from the queue so consecutive codes have no gap.
                    w_pop           = 1'b1;
                    w_out_nxt       = w_head_dec;
                    w_out_valid_nxt = 1'b1;
                    w_cnt_nxt       = HOLD_M1;
                end else begin
                    w_out_nxt       = '0;
                    w_out_valid_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_out_nxt       = '0;
                w_out_valid_nxt = 1'b0;
                w_cnt_nxt       = '0;
            end
        endcase
    end

    // Registered outputs and hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= idx;
        end
    end

endmodule

// File: tb/tb_onehot_seq_dec.sv
// Scoreboard bench for onehot_seq_dec: accepted indices expand into HOLD
// expected one-hot codes; a monitor pops them whenever out_valid is high.
module tb_onehot_seq_dec;

    localparam int unsigned N     = 8;
    localparam int unsigned HOLD  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] idx = IW'(5);
    logic          idx_valid = 1'b1;
    logic          idx_ready;
    logic [N-1:0]  out;
    logic          out_valid;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Reference model state: pending indices and cycles left on the current code.
    int           mq[$];
    logic [N-1:0] sbq[$];
    int           rem = 0;
    bit           started = 1'b0;

    onehot_seq_dec #(.N(N), .HOLD(HOLD), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .idx       (idx),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: FIFO of indices, each shown for HOLD cycles, next one
    // loaded in the last cycle of the previous; ready reflects pre-edge occupancy.
    always @(posedge clk) begin
        bit acc;
        started = 1'b1;
        if (rst) begin
            mq.delete();
            sbq.delete();
            rem = 0;
        end else begin
            acc = idx_valid && (mq.size() != DEPTH);
            if (rem <= 1 && mq.size() != 0) begin
                void'(mq.pop_front());
                rem = HOLD;
            end else if (rem > 0) begin
                rem--;
            end
            if (acc) begin
                mq.push_back(int'(idx));
                for (int h = 0; h < HOLD; h++) sbq.push_back(N'(1) << idx);
            end
        end
    end

    // Monitor: compare DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0] e;
        if (started) begin
            chk("idx_ready", 32'(idx_ready), 32'(!rst && (mq.size() != DEPTH)));
            chk("out_valid", 32'(out_valid), 32'(rem > 0));
            chk("busy", 32'(busy), 32'((rem > 0) || (mq.size() != 0)));
            chk("onehot", 32'($countones(out) <= 1), 32'(1));
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_code: got %0h expected none at %0t", out, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("out_code", 32'(out), 32'(e));
                end
            end else begin
                chk("out_idle", 32'(out), 32'(0));
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int v);
        idx       = IW'(v);
        idx_valid = 1'b1;
        tick(1);
        idx_valid = 1'b0;
    endtask

    initial begin
        int  n;
        int  guard;
        logic rdy;

        // Reset with a pending input that must not be accepted.
        tick(2);
        chk("rst_out", 32'(out), 32'(0));
        chk("rst_ready", 32'(idx_ready), 32'(0));
        rst       = 1'b0;
        idx_valid = 1'b0;
        #1;
        chk("ready_after_rst", 32'(idx_ready), 32'(1));
        tick(3);

        // Single code with explicit latency checks.
        idx       = IW'(3);
        idx_valid = 1'b1;
        tick(1);
        idx_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            chk("single_out", 32'(out), (i <= 4) ? 32'h08 : 32'h00);
            chk("single_busy", 32'(busy), (i <= 4) ? 32'd1 : 32'd0);
        end

        // Back-to-back codes, contiguous output.
        send(7); send(0); send(5);
        tick(16);

        // Backpressure: hold valid, advance idx only when accepted.
        n = 0;
        guard = 0;
        idx = IW'(0);
        idx_valid = 1'b1;
        while (n < 8 && guard < 200) begin
            @(negedge clk);
            rdy = idx_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                n++;
                idx = IW'(n);
            end
            guard++;
        end
        idx_valid = 1'b0;
        chk("full_accepted", 32'(n), 32'(8));
        tick(40);

        // Reset mid-run with two indices queued.
        send(1); send(2); send(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_out", 32'(out), 32'(0));
        chk("midrst_valid", 32'(out_valid), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        tick(10);

        // Sweep all indices, spaced out.
        for (int v = 0; v < 8; v++) begin
            send(v);
            tick(5);
        end
        tick(6);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            idx_valid = ($urandom_range(0, 9) < 6);
            idx       = IW'($urandom_range(0, N - 1));
            rst       = ($urandom_range(0, 149) == 0);
            tick(1);
        end
        rst       = 1'b0;
        idx_valid = 1'b0;
        tick(50);
        chk("drain_sb", 32'(sbq.size()), 32'(0));
        chk("drain_idle", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/onehot_seq_dec.md
# onehot_seq_dec

Sequenced index-to-one-hot decoder: the receiving end of the priority-encoder path. Accepts 3-bit indices over a valid/ready handshake, queues them in a small FIFO, and replays each as a one-hot output vector held for a fixed number of cycles. Sits downstream of the priority encoder and drives per-line strobe/select logic.

## Interface
- N, 8, output vector width; power of two, 2..256; index width IW = log2(N)
- HOLD, 4, cycles each one-hot code is driven; >= 1
- DEPTH, 4, index FIFO depth; power of two, >= 2

- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  synchronous reset, active-high
- idx  input  IW  index to decode
- idx_valid  input  1  idx is valid this cycle
- idx_ready  output  1  block can accept idx this cycle
- out  output  N  one-hot decoded vector; all-zero when idle
- out_valid  output  1  out carries a code
- busy  output  1  out_valid high or FIFO non-empty

## Operation
- Input transfer occurs on a rising edge where idx_valid && idx_ready; idx is pushed into the FIFO.
- idx_ready = !rst && (count != DEPTH); depends only on registered count, with no combinational path from the output side. When full, it stays low even if a pop occurs that same cycle.
- While idx_valid is high and idx_ready low, idx is held by the source and not consumed. The block tolerates idx changing while unaccepted.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH, count 0..DEPTH (IW-independent width log2(DEPTH)+1). Simultaneous push and pop leaves count unchanged.
- Output FSM, two states:
  - IDLE: out=0, out_valid=0. If count != 0: pop head, out <= 1 << head, out_valid <= 1, hold counter cnt <= HOLD-1, go to DRIVE.
  - DRIVE: if cnt != 0, decrement and keep out. If cnt == 0 and count != 0, pop head, reload out and cnt <= HOLD-1, stay in DRIVE (no gap). If cnt == 0 and count == 0, out <= 0, out_valid <= 0, go to IDLE.
- Pop occurs only on the FSM load/reload edge. The FIFO never pops when empty or pushes when full.
- Order is strictly FIFO. Every accepted index appears exactly once, for exactly HOLD cycles.
- busy = out_valid || (count != 0), combinational from registers.

## Timing
- Reset sets count=0, pointers=0, state IDLE, cnt=0, out=0, out_valid=0, busy=0. idx_ready is 0 while rst is high and 1 in the first cycle after.
- Reset mid-operation discards the current code and all queued indices. An input presented during reset is not accepted.
- Latency: an index accepted at edge k into an empty FIFO in IDLE is popped at edge k+1. out is valid from k+1 through k+HOLD, and clears at edge k+HOLD+1 if no successor is queued.
- Throughput is one index per HOLD cycles. With HOLD=1 and a continuous stream, out changes every cycle and idx_ready never drops.
- All outputs are registered except idx_ready and busy, which are simple functions of registered state and rst.

## Test plan
- Reset: hold rst=1 for 2 cycles with idx_valid=1, idx=5 -> out=8'h00, out_valid=0, busy=0, idx_ready=0 during reset. idx_ready=1 afterwards, and idx 5 is not emitted until presented post-reset.
- Single code: N=8, HOLD=4, idx=3 accepted at edge k -> out=8'b0000_1000 and out_valid=1 for cycles k+1..k+4. At k+5, out=8'h00, out_valid=0, busy=0.
- Back-to-back: idx 7, 0, 5 on three consecutive edges -> out=8'h80 ×4, then 8'h01 ×4, then 8'h20 ×4, contiguous with no idle cycle. out_valid stays high for 12 cycles.
- Full/backpressure: DEPTH=4, HOLD=4, idx_valid held high with idx 0..7 -> accepts at edges 0–4, then idx_ready=0 after edge 4. It re-asserts one cycle after the pop at edge 5, then accepts one index per 4 cycles. Output order is 0,1,2,… with no index lost or duplicated.
- Reset mid-run: rst=1 for one cycle while in DRIVE with 2 indices queued -> next cycle out=0, out_valid=0, busy=0. The queued indices never appear.
- Sweep: each idx 0..7 applied once, spaced by 6 cycles -> out equals 1<<idx exactly HOLD cycles each, and out has popcount ≤ 1 on every cycle.
